nm_sparse_row: RTL and testbench

//  Parametrised N:M structured-sparse systolic row; successor to the fixed 2-activation sparse row.

---
 rtl/nm_sparse_row.sv | 106 ++++++++++
 tb/tb_nm_sparse_row.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nm_sparse_row.sv
// nm_sparse_row: N:M structured-sparse systolic row with double-buffered weight banks
module nm_sparse_row #(
  parameter int COL = 4,
  parameter int BW = 4,
  parameter int PSUM_BW = 20,
  parameter int N = 2,
  parameter int M = 4,
  parameter int GROUPS = 2,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [N*BW-1:0]        w_data,
  input  logic [N*IW-1:0]        w_idx,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [M*BW-1:0]        a_data,
  input  logic [COL*PSUM_BW-1:0] psum_in_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] psum_out_flat,
  output logic                   bank_sel
);
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  typedef enum logic [1:0] {EMPTY, IDLE, ACC} state_t;
  state_t state;
  logic [N*BW-1:0] w_mem [2][COL][GROUPS];
  logic [N*IW-1:0] i_mem [2][COL][GROUPS];
  logic shadow_full, swap_now, fire, w_fire, last_g, wl_g, wl_c, shadow_bank;
  logic [GW-1:0] g, w_grp;
  logic [CW-1:0] w_col;
  logic [COL-1:0][PSUM_BW-1:0] acc, nxt;
  logic [M-1:0][BW-1:0] a_arr;
  logic signed [2*BW-1:0] wk, ak, p;
  assign a_arr = a_data;
  assign swap_now = shadow_full && state != ACC;
  assign a_ready = state != EMPTY && !swap_now && !(out_valid && !out_ready);
  assign w_ready = !shadow_full;
  assign fire = a_valid && a_ready;
  assign w_fire = w_valid && w_ready;
  assign last_g = g == GW'(GROUPS - 1);
  assign wl_g = w_grp == GW'(GROUPS - 1);
  assign wl_c = w_col == CW'(COL - 1);
  // the very first load fills the bank already selected; later loads fill the idle bank
  assign shadow_bank = state == EMPTY ? bank_sel : !bank_sel;
  // per-column running sum: start from psum_in on the first beat, add each kept weight times its selected activation
  always_comb begin
    wk = '0;
    ak = '0;
    p = '0;
    for (int c = 0; c < COL; c++) begin
      nxt[c] = state == IDLE ? psum_in_flat[c*PSUM_BW +: PSUM_BW] : acc[c];
      for (int k = 0; k < N; k++) begin
        wk = (2*BW)'($signed(w_mem[bank_sel][c][g][k*BW +: BW]));
        ak = (2*BW)'($signed(a_arr[i_mem[bank_sel][c][g][k*IW +: IW]]));
        p = wk * ak;
        nxt[c] = nxt[c] + PSUM_BW'(p);
      end
    end
  end
  // weight storage write port into the shadow bank
  always_ff @(posedge clk)
    if (w_fire) begin
      w_mem[shadow_bank][w_col][w_grp] <= w_data;
      i_mem[shadow_bank][w_col][w_grp] <= w_idx;
    end
  // load counters, bank swap, pass FSM and registered result
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      bank_sel <= 1'b0;
      shadow_full <= 1'b0;
      w_col <= '0;
      w_grp <= '0;
      g <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      psum_out_flat <= '0;
    end else begin
      if (w_fire) begin
        w_grp <= wl_g ? '0 : w_grp + 1'b1;
        if (wl_g) w_col <= wl_c ? '0 : w_col + 1'b1;
        if (wl_g && wl_c) shadow_full <= 1'b1;
      end
      if (swap_now) begin
        shadow_full <= 1'b0;
        bank_sel <= state == EMPTY ? bank_sel : !bank_sel;
        if (state == EMPTY) state <= IDLE;
      end
      if (fire) begin
        g <= last_g ? '0 : g + 1'b1;
        state <= last_g ? IDLE : ACC;
        acc <= nxt;
      end
      if (fire && last_g) begin
        out_valid <= 1'b1;
        psum_out_flat <= nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        psum_out_flat <= '0;
      end
    end
endmodule

// File: tb/tb_nm_sparse_row.sv
// tb_nm_sparse_row: scoreboard bench for the N:M sparse row
module tb_nm_sparse_row;
  localparam int COL = 4, BW = 4, PSUM_BW = 20, N = 2, M = 4, GROUPS = 2, IW = 2;
  localparam int VW = COL * PSUM_BW;
  logic clk = 1'b0, reset, w_valid, w_ready, a_valid, a_ready, out_valid, out_ready, bank_sel;
  logic [N*BW-1:0] w_data;
  logic [N*IW-1:0] w_idx;
  logic [M*BW-1:0] a_data;
  logic [VW-1:0] psum_in_flat, psum_out_flat;
  int n_chk = 0, n_pass = 0, w0;
  logic [VW-1:0] sb[$];
  logic signed [BW-1:0] sw_w[COL][GROUPS][N], aw_w[COL][GROUPS][N];
  logic [IW-1:0] sw_i[COL][GROUPS][N], aw_i[COL][GROUPS][N];
  logic signed [BW-1:0] act[GROUPS][M];
  logic bk = 1'b0;
  bit empty = 1'b1;
  nm_sparse_row #(.COL(COL), .BW(BW), .PSUM_BW(PSUM_BW), .N(N), .M(M), .GROUPS(GROUPS)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .psum_in_flat(psum_in_flat),
    .out_valid(out_valid), .out_ready(out_ready), .psum_out_flat(psum_out_flat), .bank_sel(bank_sel)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  function automatic logic [VW-1:0] model(input logic [VW-1:0] pin);
    logic [VW-1:0] r;
    int s;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int g = 0; g < GROUPS; g++)
        for (int k = 0; k < N; k++)
          s += int'(aw_w[c][g][k]) * int'(act[g][aw_i[c][g][k]]);
      r[c*PSUM_BW +: PSUM_BW] = pin[c*PSUM_BW +: PSUM_BW] + PSUM_BW'(s);
    end
    return r;
  endfunction
  task automatic set_w(input int wa, input int wb, input int ia, input int ib);
    for (int c = 0; c < COL; c++)
      for (int g = 0; g < GROUPS; g++) begin
        sw_w[c][g][0] = BW'(wa);
        sw_w[c][g][1] = BW'(wb);
        sw_i[c][g][0] = IW'(ia);
        sw_i[c][g][1] = IW'(ib);
      end
  endtask
  task automatic set_act(input int g, input int a0, input int a1, input int a2, input int a3);
    act[g][0] = BW'(a0);
    act[g][1] = BW'(a1);
    act[g][2] = BW'(a2);
    act[g][3] = BW'(a3);
  endtask
  task automatic load();
    int t;
    for (int c = 0; c < COL; c++)
      for (int g = 0; g < GROUPS; g++) begin
        w_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
          w_data[k*BW +: BW] = sw_w[c][g][k];
          w_idx[k*IW +: IW] = sw_i[c][g][k];
        end
        t = 0;
        @(negedge clk);
        while (!w_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) check("w_timeout", 0, 1);
        @(posedge clk);
        #1;
      end
    w_valid = 1'b0;
  endtask
  task automatic wait_swap();
    int t = 0;
    if (!empty) bk = !bk;
    empty = 1'b0;
    while (!(bank_sel === bk && w_ready) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("swap_bank", bank_sel, bk);
    check("swap_w_ready", w_ready, 1);
    aw_w = sw_w;
    aw_i = sw_i;
  endtask
  task automatic run_pass(input logic [VW-1:0] pin, input logic [VW-1:0] exp, output int first_wait);
    int t;
    first_wait = 0;
    for (int g = 0; g < GROUPS; g++) begin
      a_valid = 1'b1;
      psum_in_flat = pin;
      for (int j = 0; j < M; j++) a_data[j*BW +: BW] = act[g][j];
      if (g == GROUPS - 1) sb.push_back(exp);
      t = 0;
      @(negedge clk);
      while (!a_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("a_timeout", 0, 1);
      if (g == 0) first_wait = t;
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (out_valid && out_ready && !reset) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else check("psum", psum_out_flat, sb.pop_front());
    end
  initial begin
    reset = 1'b1;
    w_valid = 1'b0;
    a_valid = 1'b0;
    out_ready = 1'b1;
    w_data = '0;
    w_idx = '0;
    a_data = '0;
    psum_in_flat = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_w_ready", w_ready, 1);
    check("rst_a_ready", a_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_psum", psum_out_flat, 0);
    check("rst_bank", bank_sel, 0);
    set_w(1, 2, 0, 2);
    load();
    wait_swap();
    set_act(0, 1, 2, 3, 4);
    set_act(1, 5, 6, 7, 8);
    run_pass({COL{20'd10}}, {COL{20'd36}}, w0);
    set_w(3, 3, 1, 1);
    load();
    wait_swap();
    set_act(0, 0, 2, 0, 0);
    set_act(1, 0, 2, 0, 0);
    run_pass('0, {COL{20'd24}}, w0);
    set_w(-1, 0, 0, 1);
    load();
    wait_swap();
    set_act(0, 3, 0, 0, 0);
    set_act(1, 0, 0, 0, 0);
    run_pass('0, {COL{20'hFFFFD}}, w0);
    set_w(1, 2, 0, 2);
    load();
    wait_swap();
    set_act(0, 1, 2, 3, 4);
    set_act(1, 5, 6, 7, 8);
    out_ready = 1'b0;
    run_pass({COL{20'd10}}, {COL{20'd36}}, w0);
    repeat (5) begin
      @(negedge clk);
      check("stall_a_ready", a_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_psum", psum_out_flat, {COL{20'd36}});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    run_pass({COL{20'd10}}, {COL{20'd36}}, w0);
    check("b2b_first_beat", w0, 0);
    a_valid = 1'b1;
    for (int j = 0; j < M; j++) a_data[j*BW +: BW] = act[0][j];
    @(negedge clk);
    check("pre_reset_a_ready", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_w_ready", w_ready, 1);
    check("midrst_bank", bank_sel, 0);
    reset = 1'b0;
    bk = 1'b0;
    empty = 1'b1;
    load();
    wait_swap();
    run_pass({COL{20'd10}}, {COL{20'd36}}, w0);
    set_w(1, 1, 0, 2);
    fork
      load();
      begin
        repeat (7) @(posedge clk);
        #1;
        run_pass({COL{20'd10}}, {COL{20'd36}}, w0);
      end
    join
    wait_swap();
    run_pass({COL{20'd10}}, {COL{20'd26}}, w0);
    set_w(1, 2, 0, 2);
    load();
    wait_swap();
    set_act(0, 4, 0, 6, 0);
    set_act(1, 4, 0, 6, 0);
    run_pass({COL{20'hFFFF0}}, {COL{20'h00010}}, w0);
    set_act(0, 0, 0, 0, 0);
    set_act(1, 0, 0, 0, 0);
    run_pass('0, '0, w0);
    for (int r = 0; r < 4; r++) begin
      logic [VW-1:0] pin;
      for (int c = 0; c < COL; c++)
        for (int g = 0; g < GROUPS; g++)
          for (int k = 0; k < N; k++) begin
            sw_w[c][g][k] = BW'($urandom_range(15));
            sw_i[c][g][k] = IW'($urandom_range(3));
          end
      load();
      wait_swap();
      for (int g = 0; g < GROUPS; g++)
        for (int j = 0; j < M; j++) act[g][j] = BW'($urandom_range(15));
      for (int c = 0; c < COL; c++) pin[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
      run_pass(pin, model(pin), w0);
    end
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    #1 check("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
